// File: rtl/pid_controller.sv
// pid_controller: memory-mapped fixed-point PID with a shared multiplier and symmetric output clamp
module pid_controller #(
   parameter int FRAC_BITS = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chipSelect,
   input  logic              write,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       writeData,
   output logic [31:0]       readData,
   input  logic              sampleTick,
   input  logic [31:0]       measurement,
   output logic [31:0]       pidOut,
   output logic              outValid,
   output logic              busy
);
   typedef enum logic [2:0] {IDLE, ERR, PTERM, ITERM, DTERM, SAT} state_t;
   state_t state, state_nx;
   logic enable, clr_pend, overrun, sat, sat_pos;
   logic signed [31:0] setpoint, kp, ki, kd, integ, e_prev, e, kp_s, ki_s, kd_s;
   logic [31:0] out_lim, rd_mux;
   logic [30:0] lim_s;
   logic signed [65:0] acc, acc_nx, y, lim;
   logic signed [31:0] mul_a, mul_b, integ_new, de, y_out;
   logic signed [63:0] prod;
   logic wr, rd, clr, start, hold, y_pos, y_neg;

   function automatic logic signed [31:0] sat32(input logic signed [32:0] v);
      return (v[32] != v[31]) ? (v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : v[31:0];
   endfunction

   assign wr = chipSelect & write;
   assign rd = chipSelect & read & ~write;
   assign clr = clr_pend | (wr && address == ADDR_W'(0) && writeData[1]);
   assign start = state == IDLE && sampleTick && enable;
   assign busy = state != IDLE;

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = start ? ERR : IDLE;
         ERR:     state_nx = PTERM;
         PTERM:   state_nx = ITERM;
         ITERM:   state_nx = DTERM;
         DTERM:   state_nx = SAT;
         default: state_nx = IDLE;
      endcase
   end

   // anti-windup: freeze the integrator while pushing further into the active clamp
   always_comb begin
      hold = sat && (sat_pos ? (!e[31] && e != 0) : e[31]);
      integ_new = hold ? integ : sat32({integ[31], integ} + {e[31], e});
      de = sat32({e[31], e} - {e_prev[31], e_prev});
      mul_a = state == ITERM ? ki_s : state == DTERM ? kd_s : kp_s;
      mul_b = state == ITERM ? integ_new : state == DTERM ? de : e;
      prod = 64'(mul_a) * 64'(mul_b);
      acc_nx = acc + {{2{prod[63]}}, prod};
      y = acc >>> FRAC_BITS;
      lim = {35'd0, lim_s};
      y_pos = y > lim;
      y_neg = y < -lim;
      y_out = y_pos ? {1'b0, lim_s} : y_neg ? -{1'b0, lim_s} : y[31:0];
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_W'(0): rd_mux = {31'd0, enable};
         ADDR_W'(1): rd_mux = setpoint;
         ADDR_W'(2): rd_mux = kp;
         ADDR_W'(3): rd_mux = ki;
         ADDR_W'(4): rd_mux = kd;
         ADDR_W'(5): rd_mux = out_lim;
         ADDR_W'(6): rd_mux = {29'd0, overrun, sat, busy};
         ADDR_W'(7): rd_mux = integ;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         enable <= 1'b0;
         clr_pend <= 1'b0;
         overrun <= 1'b0;
         sat <= 1'b0;
         sat_pos <= 1'b0;
         setpoint <= '0;
         kp <= '0;
         ki <= '0;
         kd <= '0;
         out_lim <= 32'h7FFF_FFFF;
         integ <= '0;
         e_prev <= '0;
         e <= '0;
         kp_s <= '0;
         ki_s <= '0;
         kd_s <= '0;
         lim_s <= '0;
         acc <= '0;
         pidOut <= '0;
         outValid <= 1'b0;
         readData <= '0;
      end else begin
         state <= state_nx;
         outValid <= state == SAT;
         if (wr && address == ADDR_W'(0)) enable <= writeData[0];
         if (wr && address == ADDR_W'(1)) setpoint <= writeData;
         if (wr && address == ADDR_W'(2)) kp <= writeData;
         if (wr && address == ADDR_W'(3)) ki <= writeData;
         if (wr && address == ADDR_W'(4)) kd <= writeData;
         if (wr && address == ADDR_W'(5)) out_lim <= writeData;
         if (wr && address == ADDR_W'(6)) overrun <= 1'b0;
         if (sampleTick && busy) overrun <= 1'b1;
         if (rd) readData <= rd_mux;
         if (start) begin
            e <= sat32({setpoint[31], setpoint} - {measurement[31], measurement});
            kp_s <= kp;
            ki_s <= ki;
            kd_s <= kd;
            lim_s <= out_lim[30:0];
         end
         if (state == ERR) acc <= '0;
         if (state == PTERM || state == ITERM || state == DTERM) acc <= acc_nx;
         if (state == ITERM) integ <= integ_new;
         if (state == SAT) begin
            pidOut <= y_out;
            sat <= y_pos | y_neg;
            sat_pos <= y_pos;
            e_prev <= e;
         end
         // a clear overrides the SAT-edge updates so it lands after pidOut is written
         if (clr && (state == IDLE || state == SAT)) begin
            integ <= '0;
            e_prev <= '0;
            sat <= 1'b0;
            clr_pend <= 1'b0;
         end else clr_pend <= clr;
      end
   end
endmodule

// File: tb/tb_pid_controller.sv
// tb_pid_controller: scoreboard-driven bench for pid_controller
module tb_pid_controller;
   localparam logic [31:0] MAXL = 32'h7FFF_FFFF;
   logic clk = 0, rst = 1, chipSelect = 0, write = 0, read = 0, sampleTick = 0;
   logic [2:0] address = 0;
   logic [31:0] writeData = 0, measurement = 0;
   logic [31:0] readData, pidOut;
   logic outValid, busy;
   int total = 0, bad = 0, valid_cnt = 0;
   logic [31:0] exp_q[$];

   pid_controller #(.FRAC_BITS(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .chipSelect(chipSelect), .write(write), .read(read),
      .address(address), .writeData(writeData), .readData(readData),
      .sampleTick(sampleTick), .measurement(measurement), .pidOut(pidOut),
      .outValid(outValid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (outValid) valid_cnt++;

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipSelect = 1; write = 1; address = a; writeData = d;
      @(posedge clk); #1;
      chipSelect = 0; write = 0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      chipSelect = 1; read = 1; address = a;
      @(posedge clk); #1;
      chipSelect = 0; read = 0; d = readData;
   endtask

   task automatic setup(input logic [31:0] p, input logic [31:0] i, input logic [31:0] d,
                        input logic [31:0] sp, input logic [31:0] lim);
      bus_write(2, p); bus_write(3, i); bus_write(4, d);
      bus_write(1, sp); bus_write(5, lim); bus_write(0, 3);
   endtask

   task automatic run_sample(input logic [31:0] m, output int lat, output logic [31:0] got);
      measurement = m; sampleTick = 1;
      @(posedge clk); #1;
      sampleTick = 0; lat = -1; got = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (outValid) begin lat = i; got = pidOut; break; end
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst = 1; repeat (3) @(posedge clk); #1; rst = 0;
      total++; if (pidOut !== 0) begin bad++; $display("FAIL reset_pidout got=%h want=0", pidOut); end
      total++; if (outValid !== 0) begin bad++; $display("FAIL reset_valid got=%b want=0", outValid); end
      total++; if (busy !== 0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (readData !== 0) begin bad++; $display("FAIL reset_rdata got=%h want=0", readData); end
      bus_read(5, d);
      total++; if (d !== MAXL) begin bad++; $display("FAIL reset_outlim got=%h want=%h", d, MAXL); end
      bus_read(2, d);
      total++; if (d !== 0) begin bad++; $display("FAIL reset_kp got=%h want=0", d); end
      bus_read(6, d);
      total++; if (d !== 0) begin bad++; $display("FAIL reset_status got=%h want=0", d); end
   endtask

   task automatic test_proportional;
      int lat; logic [31:0] got, ex, d;
      setup(256, 0, 0, 1000, MAXL);
      exp_q.push_back(600);
      run_sample(400, lat, got); ex = exp_q.pop_front();
      total++; if (lat !== 5) begin bad++; $display("FAIL p_latency got=%0d want=5", lat); end
      total++; if (got !== ex) begin bad++; $display("FAIL p_out got=%0d want=%0d", $signed(got), $signed(ex)); end
      @(posedge clk); #1;
      total++; if (outValid !== 0) begin bad++; $display("FAIL p_valid_width got=%b want=0", outValid); end
      bus_read(6, d);
      total++; if (d !== 0) begin bad++; $display("FAIL p_status got=%h want=0", d); end
   endtask

   task automatic test_saturation;
      int lat; logic [31:0] got, ex, d;
      bus_write(5, 500);
      exp_q.push_back(500);
      run_sample(400, lat, got); ex = exp_q.pop_front();
      total++; if (got !== ex) begin bad++; $display("FAIL sat_pos got=%0d want=%0d", $signed(got), $signed(ex)); end
      bus_read(6, d);
      total++; if (d !== 2) begin bad++; $display("FAIL sat_status got=%h want=2", d); end
      exp_q.push_back(-32'sd500);
      run_sample(1600, lat, got); ex = exp_q.pop_front();
      total++; if (got !== ex) begin bad++; $display("FAIL sat_neg got=%0d want=%0d", $signed(got), $signed(ex)); end
   endtask

   task automatic test_integral;
      int lat; logic [31:0] got, ex, d;
      setup(0, 128, 0, 1000, MAXL);
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(50 * k);
         run_sample(900, lat, got); ex = exp_q.pop_front();
         total++; if (got !== ex) begin bad++; $display("FAIL integ_out%0d got=%0d want=%0d", k, $signed(got), $signed(ex)); end
         bus_read(7, d);
         total++; if (d !== 100 * k) begin bad++; $display("FAIL integ_val%0d got=%0d want=%0d", k, d, 100 * k); end
      end
      bus_write(5, 120);
      for (int k = 4; k <= 5; k++) begin
         exp_q.push_back(120);
         run_sample(900, lat, got); ex = exp_q.pop_front();
         total++; if (got !== ex) begin bad++; $display("FAIL windup_out%0d got=%0d want=%0d", k, $signed(got), $signed(ex)); end
         bus_read(7, d);
         total++; if (d !== 400) begin bad++; $display("FAIL windup_integ%0d got=%0d want=400", k, d); end
      end
   endtask

   task automatic test_derivative;
      int lat; logic [31:0] got, ex;
      setup(0, 0, 256, 1000, MAXL);
      exp_q.push_back(100);
      run_sample(900, lat, got); ex = exp_q.pop_front();
      total++; if (got !== ex) begin bad++; $display("FAIL d_first got=%0d want=%0d", $signed(got), $signed(ex)); end
      exp_q.push_back(50);
      run_sample(850, lat, got); ex = exp_q.pop_front();
      total++; if (got !== ex) begin bad++; $display("FAIL d_second got=%0d want=%0d", $signed(got), $signed(ex)); end
      bus_write(0, 3);
      exp_q.push_back(150);
      run_sample(850, lat, got); ex = exp_q.pop_front();
      total++; if (got !== ex) begin bad++; $display("FAIL d_cleared got=%0d want=%0d", $signed(got), $signed(ex)); end
   endtask

   task automatic test_overrun;
      int c0; logic [31:0] ex, d;
      setup(256, 0, 0, 1000, MAXL);
      bus_write(6, 0);
      exp_q.push_back(600);
      c0 = valid_cnt; measurement = 400; sampleTick = 1;
      @(posedge clk); #1; sampleTick = 0;
      @(posedge clk); #1; sampleTick = 1;
      @(posedge clk); #1; sampleTick = 0;
      repeat (8) @(posedge clk); #1;
      ex = exp_q.pop_front();
      total++; if (valid_cnt - c0 !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", valid_cnt - c0); end
      total++; if (pidOut !== ex) begin bad++; $display("FAIL ovr_out got=%0d want=%0d", $signed(pidOut), $signed(ex)); end
      bus_read(6, d);
      total++; if (d !== 4) begin bad++; $display("FAIL ovr_status got=%h want=4", d); end
      bus_write(6, 0);
      bus_read(6, d);
      total++; if (d !== 0) begin bad++; $display("FAIL ovr_clear got=%h want=0", d); end
   endtask

   task automatic test_bus;
      logic [31:0] d;
      bus_read(2, d);
      total++; if (d !== 256) begin bad++; $display("FAIL bus_kp got=%0d want=256", d); end
      chipSelect = 1; write = 1; read = 1; address = 2; writeData = 77;
      @(posedge clk); #1;
      chipSelect = 0; write = 0; read = 0;
      total++; if (readData !== 256) begin bad++; $display("FAIL bus_wr_prio got=%0d want=256", readData); end
      bus_read(2, d);
      total++; if (d !== 77) begin bad++; $display("FAIL bus_kp_new got=%0d want=77", d); end
      bus_write(0, 7);
      bus_read(0, d);
      total++; if (d !== 1) begin bad++; $display("FAIL bus_ctrl got=%h want=1", d); end
   endtask

   task automatic test_reset_mid;
      int c0; logic [31:0] d;
      c0 = valid_cnt; measurement = 400; sampleTick = 1;
      @(posedge clk); #1; sampleTick = 0;
      repeat (3) @(posedge clk); #1;
      total++; if (busy !== 1) begin bad++; $display("FAIL rm_busy_before got=%b want=1", busy); end
      rst = 1;
      @(posedge clk); #1;
      total++; if (pidOut !== 0) begin bad++; $display("FAIL rm_pidout got=%0d want=0", pidOut); end
      total++; if (busy !== 0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
      total++; if (outValid !== 0) begin bad++; $display("FAIL rm_valid got=%b want=0", outValid); end
      rst = 0;
      repeat (6) @(posedge clk); #1;
      total++; if (valid_cnt !== c0) begin bad++; $display("FAIL rm_no_pulse got=%0d want=%0d", valid_cnt, c0); end
      bus_read(5, d);
      total++; if (d !== MAXL) begin bad++; $display("FAIL rm_outlim got=%h want=%h", d, MAXL); end
      bus_read(2, d);
      total++; if (d !== 0) begin bad++; $display("FAIL rm_kp got=%0d want=0", d); end
   endtask

   initial begin
      test_reset;
      test_proportional;
      test_saturation;
      test_integral;
      test_derivative;
      test_overrun;
      test_bus;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Fixed-point, memory-mapped PID controller that computes the signed control effort consumed by the PID-to-timer link stage.
- On each sampleTick it latches a signed measurement, computes P, I and D terms sequentially through a shared multiplier, then scales and clamps the result.
- The clamped result is presented on pidOut with a one-cycle outValid pulse.
- Gains, setpoint and limits are programmed over the same chipSelect/write/read bus used by the other peripherals.

Parameters:
- FRAC_BITS, 8, number of fractional bits in the KP/KI/KD gains (Q(31-FRAC_BITS).FRAC_BITS signed).
- ADDR_W, 3, register address width.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- chipSelect, input, 1, bus select.
- write, input, 1, write strobe (qualified by chipSelect).
- read, input, 1, read strobe (qualified by chipSelect).
- address, input, ADDR_W, register index.
- writeData, input, 32, bus write data.
- readData, output, 32, registered bus read data.
- sampleTick, input, 1, one-cycle sample request.
- measurement, input, 32, signed process measurement.
- pidOut, output, 32, signed clamped control effort (to the link stage's pid_in).
- outValid, output, 1, one-cycle pulse when pidOut updates.
- busy, output, 1, high while the FSM is not IDLE.

Behaviour:
- Register map:
  - 0 CTRL: bit0 enable, bit1 clearInteg (self-clearing), bit2 always reads 0.
  - 1 SETPOINT, signed.
  - 2 KP, 3 KI, 4 KD: signed gains.
  - 5 OUT_LIM: bits[30:0] are a magnitude; bit31 is ignored on use but stored.
  - 6 STATUS, read-only: bit0 busy, bit1 sat (last output clamped), bit2 overrun (sticky); any write to address 6 clears overrun.
  - 7 INTEG: read-only, integrator value.
- Reset values: every register 0 except OUT_LIM = 32'h7FFFFFFF. pidOut=0, outValid=0, readData=0, busy=0, integrator=0, ePrev=0, FSM=IDLE.
- Bus write: chipSelect&write writes on that edge. Write has priority over read.
- Bus read: chipSelect&read&!write loads readData on the edge, so data is visible the next cycle. Otherwise readData holds its value.
- FSM states: IDLE -> ERR -> PTERM -> ITERM -> DTERM -> SAT -> IDLE, one cycle per state.
- IDLE: if sampleTick & enable, the FSM moves to ERR. On the same edge it latches:
  - e = saturate32(SETPOINT - measurement), computed at 33 bits then clamped to [-2^31, 2^31-1];
  - snapshots of KP, KI, KD and OUT_LIM.
- ERR: accumulator acc (signed, 66 bits) is set to 0.
- PTERM: acc += KP*e, using a 64-bit signed product.
- ITERM: integrator update, then acc += KI*integ_new.
  - integ_new = saturate32(integ + e).
  - The integrator is not updated (integ_new = integ) when the previous output was clamped at +limit and e>0, or at -limit and e<0. This is conditional anti-windup.
- DTERM: acc += KD*(saturate32(e - ePrev)).
- SAT:
  - y = acc >>> FRAC_BITS (arithmetic shift), clamped to [-OUT_LIM[30:0], +OUT_LIM[30:0]].
  - pidOut <= y; sat flag and its direction are updated; ePrev <= e.
- outValid is high for exactly the one cycle following the SAT edge, together with the new pidOut. Latency is 5 clocks from the edge that samples sampleTick to outValid high.
- pidOut holds between samples.
- sampleTick while busy: ignored, STATUS.overrun set to 1, the computation in progress is unaffected. sampleTick in IDLE with enable=0: ignored, no flag.
- Writes to the setpoint, gain or limit registers during busy do not affect the current computation; they apply from the next sample.
- Deasserting enable mid-computation: the current computation completes and outValid still pulses.
- clearInteg:
  - In IDLE, integrator, ePrev and the sat flag clear on the next edge.
  - While busy, the request is held pending and applied on the edge where the FSM returns to IDLE, after pidOut is written.
  - If a pending clear and a sampleTick occur in the same IDLE cycle, the clear is applied first and the sample starts on that edge with integ=0 and ePrev=0.
- OUT_LIM[30:0]=0 forces pidOut=0 with sat=1 whenever the pre-clamp value y≠0.
- rst asserted mid-computation: everything returns to reset values on that edge, FSM goes to IDLE, no outValid pulse.

Test Plan:
- Proportional only (FRAC_BITS=8): KP=256, KI=KD=0, SETPOINT=1000, measurement=400, enable=1, pulse sampleTick -> outValid high exactly 5 cycles later, pidOut=600, STATUS.sat=0.
- Saturation: the P-only setup above with OUT_LIM=500 -> pidOut=500 and sat=1. Then measurement=1600 -> pidOut=-500.
- Integral with anti-windup: KP=0, KI=128, e=100, three ticks -> INTEG reads 100/200/300 and pidOut 50/100/150. Then set OUT_LIM=120, tick -> pidOut=120. Next tick with e=100 -> INTEG stays 400, pidOut=120.
- Derivative: KD=256, KP=KI=0, e=100 then e=150 -> pidOut=100 then 50. Then clearInteg in IDLE, e=150 -> pidOut=150.
- Overrun and bus: sampleTick again 2 cycles after the first -> exactly one outValid, STATUS reads 0x4 in IDLE. Write address 6 -> STATUS reads 0. Simultaneous write and read of KP -> register written, readData unchanged.
- Reset mid-operation: assert rst during the DTERM state -> next cycle pidOut=0, busy=0, no outValid, OUT_LIM reads 0x7FFFFFFF, KP reads 0.
